// File: rtl/idata_arb_if.sv
// Handshake bundle between the two byte producers, the arbiter and the downstream
// consumer of the shared output channel.
interface idata_arb_if #(
  parameter int DW = 8,
  parameter int CW = 8
);
  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          out_ready;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_src, cnt0, cnt1
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_src, cnt0, cnt1
  );
endinterface

// File: rtl/idata_arb.sv
// Two-requester round-robin arbiter feeding one registered output byte with
// valid/ready handshake, source tag and per-source delivered-byte counters.
module idata_arb #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  idata_arb_if.slave  bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          prio;
  logic          any_valid;
  logic          grant;
  logic          load;
  logic          drain;
  logic          valid_o;
  logic          ready0;
  logic          ready1;
  logic [DW-1:0] data_q;
  logic          src_q;
  logic [CW-1:0] cnt0_q;
  logic [CW-1:0] cnt1_q;

  // Grant: a lone requester wins; on contention the priority pointer decides.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    grant     = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
    load      = ((state == EMPTY) || bus.out_ready) && any_valid;
    drain     = (state == FULL) && bus.out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (load) state_nxt = FULL;
      FULL: begin
        if (load)               state_nxt = FULL;
        else if (bus.out_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    valid_o = (state == FULL);
    ready0  = load && !grant;
    ready1  = load && grant;
  end

  // Counting uses the tag of the byte being drained, not the one being loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      src_q  <= 1'b0;
      prio   <= 1'b0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (load) begin
        data_q <= grant ? bus.req1_data : bus.req0_data;
        src_q  <= grant;
        prio   <= !grant;
      end
      if (drain) begin
        if (src_q) cnt1_q <= cnt1_q + 1'b1;
        else       cnt0_q <= cnt0_q + 1'b1;
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.out_valid  = valid_o;
  assign bus.out_data   = data_q;
  assign bus.out_src    = src_q;
  assign bus.cnt0       = cnt0_q;
  assign bus.cnt1       = cnt1_q;

endmodule

// File: tb/tb_idata_arb.sv
// Scoreboard bench for idata_arb: directed stimulus pushes expected bytes, a monitor
// pops and compares them at every downstream handshake.
module tb_idata_arb;

  typedef struct {
    logic       src;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  idata_arb_if #(.DW(8), .CW(8)) bus ();

  idata_arb #(.DW(8), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic src, input logic [7:0] data);
    exp_t e;
    e.src  = src;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every downstream handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_byte", {23'd0, bus.out_src, bus.out_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", bus.out_data, e.data);
        chk("sb_src", bus.out_src, e.src);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.out_ready  = 1'b0;

    // Reset values
    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_src", bus.out_src, 0);
    chk("rst_cnt0", bus.cnt0, 0);
    chk("rst_cnt1", bus.cnt1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single source, back-to-back bytes
    step();
    bus.req0_valid = 1'b1; bus.req0_data = 8'h11; bus.out_ready = 1'b1;
    push(1'b0, 8'h11);
    @(negedge clk);
    chk("s1_req0_ready", bus.req0_ready, 1);
    chk("s1_req1_ready", bus.req1_ready, 0);
    step();
    bus.req0_data = 8'h22; push(1'b0, 8'h22);
    @(negedge clk);
    chk("s1_latency_data", bus.out_data, 8'h11);
    chk("s1_latency_valid", bus.out_valid, 1);
    step();
    bus.req0_data = 8'h33; push(1'b0, 8'h33);
    @(negedge clk);
    chk("s1_req0_ready_3", bus.req0_ready, 1);
    step();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("s1_last_data", bus.out_data, 8'h33);
    chk("s1_last_valid", bus.out_valid, 1);

    // Idle gap
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("idle_out_valid", bus.out_valid, 0);
      chk("idle_req0_ready", bus.req0_ready, 0);
      chk("idle_req1_ready", bus.req1_ready, 0);
      chk("idle_cnt0", bus.cnt0, 3);
      chk("idle_cnt1", bus.cnt1, 0);
    end

    // Backpressure: requester 1 loads into EMPTY even with out_ready low
    step();
    bus.req1_valid = 1'b1; bus.req1_data = 8'h5A; bus.out_ready = 1'b0;
    push(1'b1, 8'h5A);
    @(negedge clk);
    chk("bp_req1_ready", bus.req1_ready, 1);
    step();
    bus.req1_valid = 1'b0; bus.req0_valid = 1'b1; bus.req0_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_data", bus.out_data, 8'h5A);
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_req0_ready", bus.req0_ready, 0);
      step();
    end
    bus.out_ready = 1'b1;
    push(1'b0, 8'h77);
    @(negedge clk);
    chk("bp_release_ready", bus.req0_ready, 1);
    step();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("bp_nobubble_valid", bus.out_valid, 1);
    chk("bp_nobubble_data", bus.out_data, 8'h77);
    chk("bp_cnt1", bus.cnt1, 1);
    step();
    @(negedge clk);
    chk("bp_drain_valid", bus.out_valid, 0);
    chk("bp_cnt0", bus.cnt0, 4);

    // Reset mid-transfer (prio is 1 here; reset must bring it back to 0)
    step();
    bus.req0_valid = 1'b1; bus.req0_data = 8'hC3; bus.out_ready = 1'b0;
    step();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("mr_held_data", bus.out_data, 8'hC3);
    chk("mr_held_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_out_data", bus.out_data, 0);
    chk("mr_out_src", bus.out_src, 0);
    chk("mr_cnt0", bus.cnt0, 0);
    chk("mr_cnt1", bus.cnt1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: grants alternate starting at requester 0
    step();
    bus.req0_valid = 1'b1; bus.req0_data = 8'hA0;
    bus.req1_valid = 1'b1; bus.req1_data = 8'hB0;
    bus.out_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(k[0], k[0] ? 8'hB0 : 8'hA0);
      @(negedge clk);
      chk("ct_req0_ready", bus.req0_ready, {31'd0, ~k[0]});
      chk("ct_req1_ready", bus.req1_ready, {31'd0, k[0]});
      step();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step();
    @(negedge clk);
    chk("ct_cnt0", bus.cnt0, 2);
    chk("ct_cnt1", bus.cnt1, 2);
    chk("ct_out_valid", bus.out_valid, 0);

    // Counter wrap over 256 bytes from requester 1
    do_reset();
    bus.req1_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.req1_data = i[7:0];
      push(1'b1, i[7:0]);
      if (i == 128) begin
        @(negedge clk);
        chk("wr_cnt1_mid", bus.cnt1, 127);
      end
      step();
    end
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("wr_cnt1_255", bus.cnt1, 255);
    step();
    @(negedge clk);
    chk("wr_cnt1_wrap", bus.cnt1, 0);
    chk("wr_cnt0", bus.cnt0, 0);
    chk("wr_out_valid", bus.out_valid, 0);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idata_arb.md
# idata_arb

Two-requester, round-robin arbiter that shares the single 8-bit output channel of the `topdata` datapath between two producers. Each producer offers a byte with a valid/ready handshake. The arbiter grants one producer per cycle and captures the granted byte into an output register. It presents that byte downstream with a valid/ready handshake and a source tag, and keeps per-source delivered-byte counters for debug.

## Interface
- `DW`, 8, data width of requester and output bytes
- `CW`, 8, width of each delivered-byte counter
- `clk` input 1: rising-edge clock, the only clock
- `rst_n` input 1: asynchronous, active-low reset
- `req0_valid` input 1: requester 0 offers `req0_data`
- `req0_data` input DW: requester 0 byte
- `req0_ready` output 1: requester 0 byte accepted this cycle
- `req1_valid` input 1: requester 1 offers `req1_data`
- `req1_data` input DW: requester 1 byte
- `req1_ready` output 1: requester 1 byte accepted this cycle
- `out_valid` output 1: `out_data`/`out_src` hold a byte
- `out_data` output DW: registered granted byte
- `out_src` output 1: source of `out_data` (0 or 1)
- `out_ready` input 1: downstream accepts the byte this cycle
- `cnt0` output CW: bytes from requester 0 delivered downstream
- `cnt1` output CW: bytes from requester 1 delivered downstream

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `out_src`=0, `cnt0`=0, `cnt1`=0, priority pointer `prio`=0 (requester 0 favoured).
- Output register state machine:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `load` = (EMPTY or `out_ready`) and (`req0_valid` or `req1_valid`).
- Grant selection is combinational:
  - If only one requester is valid, that requester wins.
  - If both are valid, `prio` wins.
- `reqN_ready` = `load` and (granted == N). It is combinational from the valids, `out_ready` and state. At most one ready is high per cycle.
- On a `load` edge:
  - `out_data` ← granted data, `out_src` ← N, state → FULL.
  - `prio` ← !N, so the other requester is favoured next.
  - `prio` is unchanged when there is no load.
- FULL with `out_ready`=1 and no `load`: state → EMPTY. `out_data`/`out_src` keep their last values.
- FULL with `out_ready`=0: `out_data`/`out_src` stay stable and both readies are 0.
- Counters:
  - On `out_valid` and `out_ready`, `cnt[out_src]` increments by 1.
  - Counters wrap modulo 2^CW (255 → 0) with no saturation.
- Requester rule: a requester must hold its data stable while valid and not ready. The arbiter does not check this.

## Timing
- Accept-to-output latency: 1 cycle. A byte accepted at edge k is visible with `out_valid`=1 after edge k.
- Throughput: one byte per cycle when `out_ready` is held high. A drain and a new load on the same edge keep `out_valid`=1 with no bubble.
- Simultaneous request from both sources with `out_ready`=1: grants alternate 0,1,0,1,… starting from the current `prio`.
- A requester that drops valid loses nothing. `prio` is unaffected by the other requester's idle cycles.
- Counter update and data drain happen on the same edge. The count is visible the cycle after the handshake.
- Reset mid-operation: all outputs take their reset values immediately on `rst_n` falling, independent of `clk`. Any held byte is discarded and not counted. After `rst_n` rises, the first load can occur at the first rising edge where a requester is valid.
- Reset release has no synchronizer in this block. The integrator deasserts `rst_n` away from a `clk` rising edge.

## Test plan
- Reset then single source:
  - Stimulus: `req0_valid`=1 with data 0x11, 0x22, 0x33 on consecutive cycles; `out_ready`=1.
  - Required: `out_data` 0x11, 0x22, 0x33 one cycle later each; `out_src`=0; `cnt0`=3; `cnt1`=0.
- Both sources contend:
  - Stimulus: `req0_data`=0xA0 and `req1_data`=0xB0, both held valid for 4 cycles; `out_ready`=1.
  - Required: `out_src` sequence 0,1,0,1; `cnt0`=2; `cnt1`=2.
- Backpressure:
  - Stimulus: load 0x5A from requester 1; hold `out_ready`=0 for 5 cycles; `req0_valid`=1 throughout.
  - Required: `out_data`=0x5A stable; `req0_ready`=0 for all 5 cycles. Then `out_ready`=1 drains 0x5A and loads requester 0's byte on the same edge.
- Counter wrap:
  - Stimulus: 256 bytes from requester 1 with `out_ready`=1.
  - Required: `cnt1` passes 255 and returns to 0; `cnt0`=0.
- Reset mid-transfer:
  - Stimulus: `out_valid`=1 with 0xC3 held under `out_ready`=0; pulse `rst_n` low between clock edges.
  - Required: `out_valid`=0, `out_data`=0, counters 0, and `prio`=0 immediately. The first contended grant after release goes to requester 0.
- Idle gap:
  - Stimulus: neither requester valid for 3 cycles with `out_ready`=1 after the last byte.
  - Required: `out_valid` falls 1 cycle after the last handshake; both readies are 0; counters are unchanged.
